// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS generator/checker pair: polynomial taps,
// reference seed, checker FSM states and the tap-XOR helper.
package lfsr_pkg;

  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h088C_8892;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 32'h00BD_4410;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Tap XOR of the 32-bit PRBS state; the same block feeds both the
// generator and the checker's bit prediction.
module lfsr_feedback
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr_state,
  output logic              feedback
);

  assign feedback = lfsr_fb(lfsr_state);

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker: seeds its local LFSR from the received stream, verifies a
// run of predicted bits, then free-runs and counts bit errors while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 64,
  parameter int LOSS_COUNT = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        bit_i,
  input  logic        clear_i,
  output logic        locked_o,
  output logic        err_o,
  output logic [31:0] err_count_o,
  output logic [31:0] bit_count_o,
  output logic [1:0]  state_o
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_COUNT - 1);

  chk_state_e        state_r, state_nxt_s;
  logic [LFSR_W-1:0] lfsr_r, lfsr_nxt_s, lfsr_shift_s;
  logic [4:0]        seed_cnt_r, seed_cnt_nxt_s;
  logic [7:0]        match_cnt_r, match_cnt_nxt_s;
  logic [7:0]        loss_cnt_r, loss_cnt_nxt_s;
  logic              expected_s, mismatch_s;
  logic              err_nxt_s, err_inc_s, bit_inc_s;
  logic              locked_r, err_r;
  logic [31:0]       err_count_r, bit_count_r;

  lfsr_feedback u_feedback (
    .lfsr_state (lfsr_r),
    .feedback   (expected_s)
  );

  assign mismatch_s   = bit_i ^ expected_s;
  assign lfsr_shift_s = {lfsr_r[LFSR_W-2:0], bit_i};

  // Next-state, LFSR update and per-bit event decode; only valid bits advance anything.
  always_comb begin
    state_nxt_s     = state_r;
    lfsr_nxt_s      = lfsr_r;
    seed_cnt_nxt_s  = seed_cnt_r;
    match_cnt_nxt_s = match_cnt_r;
    loss_cnt_nxt_s  = loss_cnt_r;
    err_nxt_s       = 1'b0;
    err_inc_s       = 1'b0;
    bit_inc_s       = 1'b0;
    if (valid_i) begin
      case (state_r)
        ST_SEED: begin
          lfsr_nxt_s      = lfsr_shift_s;
          match_cnt_nxt_s = 8'd0;
          loss_cnt_nxt_s  = 8'd0;
          if (seed_cnt_r == 5'd31) begin
            seed_cnt_nxt_s = 5'd0;
            state_nxt_s    = ST_VERIFY;
          end else begin
            seed_cnt_nxt_s = seed_cnt_r + 5'd1;
          end
        end
        ST_VERIFY: begin
          lfsr_nxt_s = lfsr_shift_s;
          // An all-zero state predicts zeros forever, so it can never be trusted.
          if (mismatch_s || (lfsr_shift_s == {LFSR_W{1'b0}})) begin
            state_nxt_s     = ST_SEED;
            seed_cnt_nxt_s  = 5'd0;
            match_cnt_nxt_s = 8'd0;
          end else if (match_cnt_r == LOCK_LAST) begin
            state_nxt_s     = ST_LOCKED;
            match_cnt_nxt_s = 8'd0;
            loss_cnt_nxt_s  = 8'd0;
          end else begin
            match_cnt_nxt_s = match_cnt_r + 8'd1;
          end
        end
        ST_LOCKED: begin
          lfsr_nxt_s = {lfsr_r[LFSR_W-2:0], expected_s};
          bit_inc_s  = 1'b1;
          if (mismatch_s) begin
            err_nxt_s = 1'b1;
            err_inc_s = 1'b1;
            if (loss_cnt_r == LOSS_LAST) begin
              state_nxt_s    = ST_SEED;
              seed_cnt_nxt_s = 5'd0;
              loss_cnt_nxt_s = 8'd0;
            end else begin
              loss_cnt_nxt_s = loss_cnt_r + 8'd1;
            end
          end else begin
            loss_cnt_nxt_s = 8'd0;
          end
        end
        default: begin
          state_nxt_s     = ST_SEED;
          seed_cnt_nxt_s  = 5'd0;
          match_cnt_nxt_s = 8'd0;
          loss_cnt_nxt_s  = 8'd0;
        end
      endcase
    end else begin
      err_nxt_s = 1'b0;
    end
  end

  // FSM, LFSR and internal counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= ST_SEED;
      lfsr_r      <= {LFSR_W{1'b0}};
      seed_cnt_r  <= 5'd0;
      match_cnt_r <= 8'd0;
      loss_cnt_r  <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      lfsr_r      <= lfsr_nxt_s;
      seed_cnt_r  <= seed_cnt_nxt_s;
      match_cnt_r <= match_cnt_nxt_s;
      loss_cnt_r  <= loss_cnt_nxt_s;
    end
  end

  // Output registers; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      locked_r    <= 1'b0;
      err_r       <= 1'b0;
      err_count_r <= 32'd0;
      bit_count_r <= 32'd0;
    end else begin
      locked_r <= (state_nxt_s == ST_LOCKED);
      err_r    <= err_nxt_s;
      if (clear_i) begin
        err_count_r <= 32'd0;
        bit_count_r <= 32'd0;
      end else begin
        err_count_r <= err_inc_s ? sat_inc(err_count_r) : err_count_r;
        bit_count_r <= bit_inc_s ? sat_inc(bit_count_r) : bit_count_r;
      end
    end
  end

  assign locked_o    = locked_r;
  assign err_o       = err_r;
  assign err_count_o = err_count_r;
  assign bit_count_o = bit_count_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: table of stream segments from a PRBS
// generator, a per-cycle err_o scoreboard and hand-written reset/zero-stream cases.
module tb_lfsr_checker;
  import lfsr_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i, valid_i, bit_i, clear_i;
  logic        locked_o, err_o;
  logic [31:0] err_count_o, bit_count_o;
  logic [1:0]  state_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] gen_r;
  logic        sb_q[$];

  typedef struct {
    int          nbits;
    logic        flip;
    logic        gaps;
    logic        clr;
    logic [1:0]  st;
    logic        lock;
    logic        eo;
    logic [31:0] ec;
    logic [31:0] bc;
  } seg_t;

  seg_t segs[13];

  lfsr_checker #(.LOCK_COUNT(64), .LOSS_COUNT(8)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .bit_i       (bit_i),
    .clear_i     (clear_i),
    .locked_o    (locked_o),
    .err_o       (err_o),
    .err_count_o (err_count_o),
    .bit_count_o (bit_count_o),
    .state_o     (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic gen_bit(output logic b);
    b = gen_r[27] ^ gen_r[23] ^ gen_r[19] ^ gen_r[18] ^ gen_r[15]
      ^ gen_r[11] ^ gen_r[7] ^ gen_r[4] ^ gen_r[1];
    gen_r = {gen_r[30:0], b};
  endtask

  task automatic cycle(input logic v, input logic b, input logic c, input logic exp_err);
    logic e;
    valid_i = v;
    bit_i   = b;
    clear_i = c;
    sb_q.push_back(exp_err);
    @(posedge clk_i);
    #1;
    e = sb_q.pop_front();
    check("err_o pulse", {31'd0, err_o}, {31'd0, e});
  endtask

  task automatic run_bits(input int n, input logic flip, input logic gaps, input logic clr_last);
    logic b;
    int   g;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = int'($urandom_range(0, 2));
        for (int j = 0; j < g; j++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      gen_bit(b);
      cycle(1'b1, b ^ flip, clr_last && (i == n - 1), flip);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic lk,
                            input logic eo, input logic [31:0] ec, input logic [31:0] bc);
    check({tag, " state_o"},     {30'd0, state_o},  {30'd0, st});
    check({tag, " locked_o"},    {31'd0, locked_o}, {31'd0, lk});
    check({tag, " err_o"},       {31'd0, err_o},    {31'd0, eo});
    check({tag, " err_count_o"}, err_count_o, ec);
    check({tag, " bit_count_o"}, bit_count_o, bc);
  endtask

  initial begin
    logic saw_verify, saw_back;
    reset_i = 1'b1;
    valid_i = 1'b0;
    bit_i   = 1'b0;
    clear_i = 1'b0;
    gen_r   = LFSR_SEED;

    //            nbits flip  gaps  clr   st    lock  eo    err     bits
    segs[0]  = '{95, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0,  32'd0};
    segs[1]  = '{1,  1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'd0,  32'd0};
    segs[2]  = '{10, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'd0,  32'd10};
    segs[3]  = '{1,  1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 32'd1,  32'd11};
    segs[4]  = '{20, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 32'd1,  32'd31};
    segs[5]  = '{7,  1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 32'd8,  32'd38};
    segs[6]  = '{1,  1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'd8,  32'd39};
    segs[7]  = '{8,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'd16, 32'd47};
    segs[8]  = '{95, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'd16, 32'd47};
    segs[9]  = '{1,  1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'd16, 32'd47};
    segs[10] = '{5,  1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 32'd16, 32'd52};
    segs[11] = '{1,  1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 32'd0,  32'd0};
    segs[12] = '{3,  1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'd0,  32'd3};

    @(posedge clk_i);
    #1;
    check_outs("reset", 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset_i = 1'b0;

    for (int s = 0; s < 13; s++) begin
      run_bits(segs[s].nbits, segs[s].flip, segs[s].gaps, segs[s].clr);
      check_outs($sformatf("seg%0d", s), segs[s].st, segs[s].lock, segs[s].eo,
                 segs[s].ec, segs[s].bc);
    end

    // Reset mid-stream while locked must clear outputs before any clock edge.
    #2;
    reset_i = 1'b1;
    #1;
    check_outs("async reset", 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    run_bits(95, 1'b0, 1'b0, 1'b0);
    check_outs("relock 95", 2'd1, 1'b0, 1'b0, 32'd0, 32'd0);
    run_bits(1, 1'b0, 1'b0, 1'b0);
    check_outs("relock 96", 2'd2, 1'b1, 1'b0, 32'd0, 32'd0);
    run_bits(4, 1'b0, 1'b0, 1'b0);
    check_outs("post relock", 2'd2, 1'b1, 1'b0, 32'd0, 32'd4);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_outs("clear idle", 2'd2, 1'b1, 1'b0, 32'd0, 32'd0);

    // All-zero stream: must bounce between SEED and VERIFY, never lock.
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i    = 1'b0;
    saw_verify = 1'b0;
    saw_back   = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("zero stream lock", {30'd0, locked_o, state_o[1]}, 32'd0);
      if (state_o == 2'd1) saw_verify = 1'b1;
      if (saw_verify && (state_o == 2'd0)) saw_back = 1'b1;
      if (k == 32) check("zero k32 state", {30'd0, state_o}, 32'd1);
      if (k == 33) check("zero k33 state", {30'd0, state_o}, 32'd0);
    end
    check("zero stream toggles", {30'd0, saw_verify, saw_back}, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
